vga_sync_ctrl: RTL and testbench
================================

// Module: vga_sync_ctrl
// PURPOSE
//  Timing controller that sequences the text-mode pixel datapath.
//  - Divides the 100 MHz clk into a one-cycle pixel-enable strobe (25 MHz).
//  - Runs horizontal and vertical scan counters and drives hsync and vsync.
//  - Supplies pixel_x, pixel_y and video_on to the character/font-ROM generator.
//  - Runs on the same clk as the generator and its font ROM; no clock-domain crossing.
// PARAMETERS
//  H_DISPLAY  640  visible pixels per line
//  H_FRONT    16   horizontal front porch, in pixels
//  H_SYNC     96   hsync pulse width, in pixels
//  H_BACK     48   horizontal back porch, in pixels
//  V_DISPLAY  480  visible lines per frame
//  V_FRONT    10   vertical front porch, in lines
//  V_SYNC     2    vsync pulse width, in lines
//  V_BACK     33   vertical back porch, in lines
//  TICK_DIV   4    clk cycles per pixel; legal values 1..16
// PORTS
//  clk          in   1   100 MHz system clock
//  reset        in   1   asynchronous, active-high reset
//  p_tick       out  1   pixel enable; high for one clk every TICK_DIV clks
//  pixel_x      out  10  horizontal count, 0..H_TOTAL-1
//  pixel_y      out  10  vertical count, 0..V_TOTAL-1
//  hsync        out  1   horizontal sync, active low
//  vsync        out  1   vertical sync, active low
//  video_on     out  1   high while (pixel_x < H_DISPLAY) && (pixel_y < V_DISPLAY)
//  frame_start  out  1   one-clk pulse on the tick that wraps the scan to (0,0)
// BEHAVIOUR
//  Totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL likewise (525).
//    Both totals must be <= 1024. Violating this is an elaboration error ($error).
//  Divider:
//    - div_cnt runs 0..TICK_DIV-1 and wraps.
//    - p_tick = (div_cnt == TICK_DIV-1), combinational from the register.
//    - With TICK_DIV = 1, p_tick is constantly high after reset.
//  Horizontal counter: advances only on a clk edge with p_tick = 1.
//    - At H_TOTAL-1 it wraps to 0.
//  Vertical counter: advances on the same edge where the horizontal counter wraps.
//    - At V_TOTAL-1 it wraps to 0.
//  Between ticks all counters and all sync outputs hold their values.
//  Output timing:
//    - pixel_x and pixel_y are the counter registers, with zero added latency.
//    - hsync, vsync and video_on are registers loaded from the next-state counter
//      values, so they are cycle-aligned with pixel_x and pixel_y. No skew is allowed.
//  Sync windows:
//    - hsync = 0 when H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
//    - vsync = 0 when V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
//  frame_start = p_tick & (x == H_TOTAL-1) & (y == V_TOTAL-1), combinational.
//  Reset (asynchronous assert):
//    - div_cnt = 0, x = 0, y = 0.
//    - hsync = 1, vsync = 1, video_on = 0, so p_tick = 0 and frame_start = 0.
//  Reset deassert:
//    - The first clk edge loads video_on = 1, because (0,0) is visible.
//    - The first p_tick occurs TICK_DIV clks after release.
//  Reset mid-frame: all state returns to the reset values immediately.
//    - No partial line or partial sync pulse is completed.
//  No other inputs exist, so there are no simultaneous-event conflicts.
//    The x wrap and the y advance always occur on the same edge by construction.
// STRUCTURE
//  Shared include vga_timing.vh holds:
//    - the default 640x480@60 constants;
//    - the derived H_TOTAL and V_TOTAL;
//    - the sync-window bounds;
//    - the 10-bit coordinate width.
//  The generator uses the same include for its bounds.
//  Sub-module mod_counter (params N, W; ports clk, reset, en, q, wrap) is used
//  three times: divider, horizontal counter, vertical counter.
//  Sync and video_on decode plus the output registers stay in this module.
// TESTING
//  1. Reset held for 7 clks, then released.
//     Required: p_tick = 0 and hsync = vsync = 1 throughout reset.
//     First p_tick on clk 4 after release; video_on = 1 from clk 1.
//  2. Divider and wrap:
//     Required: exactly 3200 clks per line.
//     pixel_x sequence ... 798, 799, 0; pixel_y increments on that same edge.
//  3. hsync: falls when pixel_x = 656, rises when pixel_x = 752.
//     Required: low for 96 ticks (384 clks).
//     video_on falls when pixel_x = 640.
//  4. vsync: low for lines 490..491 only, i.e. 1600 ticks.
//     Required: frame period of 420000 ticks (1680000 clks).
//     frame_start pulses once per frame, one clk wide, when pixel_x = 799 and pixel_y = 524.
//  5. Reset asserted at pixel_x = 700, pixel_y = 491 (both syncs low).
//     Required: same-cycle asynchronous return to x = y = 0 with hsync = vsync = 1.
//     Checked without a clk edge.
//  6. TICK_DIV = 1 build: p_tick held high.
//     Required: line = 800 clks; sync windows unchanged in pixel units.

Source files
------------

// File: rtl/vga_sync_ctrl_pkg.sv
// Shared 640x480@60 timing defaults, coordinate width and window-decode helper
// used by the scan controller and the character generator.
package vga_sync_ctrl_pkg;

    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_TICK_DIV  = 4;

    localparam int DEF_H_TOTAL  = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL  = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    // Half-open window test lo <= v < hi on an unsigned coordinate.
    function automatic logic in_window(input logic [COORD_W-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_sync_ctrl_mod_counter.sv
// Modulo-N counter with enable; wrap flags the terminal count N-1.
module mod_counter
    import vga_sync_ctrl_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         wrap
);

    logic [W-1:0] r_q;

    assign q    = r_q;
    assign wrap = (r_q == W'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= wrap ? '0 : r_q + W'(1);
        end
    end

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA scan timing: pixel-enable divider, horizontal/vertical scan counters,
// registered sync and video_on aligned with the coordinate outputs.
module vga_sync_ctrl
    import vga_sync_ctrl_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int TICK_DIV  = DEF_TICK_DIV
) (
    input  logic               clk,
    input  logic               reset,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               frame_start
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
            $error("vga_sync_ctrl: H_TOTAL/V_TOTAL exceed the coordinate range");
        end
        if (TICK_DIV < 1 || TICK_DIV > 16) begin : g_bad_div
            $error("vga_sync_ctrl: TICK_DIV must be 1..16");
        end
    endgenerate

    logic [DIV_W-1:0]   w_div_cnt;
    logic               w_div_wrap;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_v_en;
    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic [COORD_W-1:0] w_x_next;
    logic [COORD_W-1:0] w_y_next;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_video_on;

    mod_counter #(.N(TICK_DIV), .W(DIV_W)) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .q     (w_div_cnt),
        .wrap  (w_div_wrap)
    );

    mod_counter #(.N(H_TOTAL), .W(COORD_W)) u_hcnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_div_wrap),
        .q     (w_x),
        .wrap  (w_h_wrap)
    );

    assign w_v_en = w_div_wrap & w_h_wrap;

    mod_counter #(.N(V_TOTAL), .W(COORD_W)) u_vcnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_v_en),
        .q     (w_y),
        .wrap  (w_v_wrap)
    );

    // Next-state coordinates let the decoded outputs land on the same edge as the counters.
    always_comb begin
        w_x_next = w_x;
        w_y_next = w_y;
        if (w_div_wrap) begin
            w_x_next = w_h_wrap ? '0 : w_x + COORD_W'(1);
            if (w_h_wrap) begin
                w_y_next = w_v_wrap ? '0 : w_y + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b0;
        end else begin
            r_hsync    <= !in_window(w_x_next, HS_START, HS_END);
            r_vsync    <= !in_window(w_y_next, VS_START, VS_END);
            r_video_on <= in_window(w_x_next, 0, H_DISPLAY) && in_window(w_y_next, 0, V_DISPLAY);
        end
    end

    assign p_tick      = (w_div_cnt == DIV_W'(TICK_DIV - 1));
    assign pixel_x     = w_x;
    assign pixel_y     = w_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign frame_start = p_tick & w_h_wrap & w_v_wrap;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Directed bench: default 640x480 build, a TICK_DIV=1 build and a reduced-size
// timing build for frame-level and mid-frame reset behaviour.
module tb_vga_sync_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;

    logic       a_tick, a_hs, a_vs, a_vo, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_hs, b_vs, b_vo, b_fs;
    logic [9:0] b_x, b_y;
    logic       c_tick, c_hs, c_vs, c_vo, c_fs;
    logic [9:0] c_x, c_y;

    vga_sync_ctrl u_dut_a (
        .clk(clk), .reset(rst_a), .p_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_vo), .frame_start(a_fs)
    );

    vga_sync_ctrl #(.TICK_DIV(1)) u_dut_b (
        .clk(clk), .reset(rst_b), .p_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_vo), .frame_start(b_fs)
    );

    // Reduced timing: H 8+2+3+2 = 15, V 4+1+2+2 = 9, TICK_DIV 2 -> 270 clks per frame.
    vga_sync_ctrl #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .TICK_DIV(2)
    ) u_dut_c (
        .clk(clk), .reset(rst_c), .p_tick(c_tick), .pixel_x(c_x), .pixel_y(c_y),
        .hsync(c_hs), .vsync(c_vs), .video_on(c_vo), .frame_start(c_fs)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int a_vo_fall = -1, a_vo_fall_x = -1, a_hs_fall = -1, a_hs_fall_x = -1;
        int a_hs_rise = -1, a_hs_rise_x = -1, a_wrap = -1, a_wrap_px = -1, a_wrap_y = -1;
        int a_vs_low = 0, a_fs_cnt = 0;
        int b_hs_fall = -1, b_hs_fall_x = -1, b_hs_rise = -1, b_vo_fall = -1;
        int b_wrap = -1, b_wrap_px = -1, b_wrap_y = -1, b_tick0 = 0;
        int c_fs_cnt = 0, c_fs_e1 = -1, c_fs_e2 = -1, c_fs_x = -1, c_fs_y = -1;
        int c_vs_low = 0, c_vs_fall = -1, c_vs_fall_x = -1, c_vs_fall_y = -1;
        logic p_a_vo, p_a_hs, p_b_vo, p_b_hs, p_c_vs;
        int p_a_x, p_b_x;
        logic found;

        // Reset held for 7 clks.
        #2;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_ptick_%0d", i), a_tick, 0);
            chk($sformatf("rst_hsync_%0d", i), a_hs, 1);
            chk($sformatf("rst_vsync_%0d", i), a_vs, 1);
        end
        chk("rst_video_on", a_vo, 0);
        chk("rst_x", a_x, 0);
        chk("rst_y", a_y, 0);
        chk("rst_frame_start", a_fs, 0);
        chk("rst_b_hsync", b_hs, 1);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        p_a_vo = a_vo; p_a_hs = a_hs; p_a_x = a_x;
        p_b_vo = b_vo; p_b_hs = b_hs; p_b_x = b_x;
        p_c_vs = c_vs;

        for (int e = 1; e <= 3300; e++) begin
            @(posedge clk); #1;
            if (e <= 4) begin
                chk($sformatf("a_ptick_clk%0d", e), a_tick, (e == 3) ? 1 : 0);
                chk($sformatf("a_x_clk%0d", e), a_x, (e == 4) ? 1 : 0);
            end
            if (e == 1) chk("a_video_on_clk1", a_vo, 1);

            if (p_a_vo && !a_vo && a_vo_fall < 0) begin a_vo_fall = e; a_vo_fall_x = a_x; end
            if (p_a_hs && !a_hs && a_hs_fall < 0) begin a_hs_fall = e; a_hs_fall_x = a_x; end
            if (!p_a_hs && a_hs && a_hs_rise < 0) begin a_hs_rise = e; a_hs_rise_x = a_x; end
            if (a_x == 0 && p_a_x != 0 && a_wrap < 0) begin a_wrap = e; a_wrap_px = p_a_x; a_wrap_y = a_y; end
            if (!a_vs) a_vs_low++;
            if (a_fs) a_fs_cnt++;

            if (!b_tick) b_tick0++;
            if (p_b_vo && !b_vo && b_vo_fall < 0) b_vo_fall = e;
            if (p_b_hs && !b_hs && b_hs_fall < 0) begin b_hs_fall = e; b_hs_fall_x = b_x; end
            if (!p_b_hs && b_hs && b_hs_rise < 0) b_hs_rise = e;
            if (b_x == 0 && p_b_x != 0 && b_wrap < 0) begin b_wrap = e; b_wrap_px = p_b_x; b_wrap_y = b_y; end

            if (c_fs && e <= 600) begin
                c_fs_cnt++;
                if (c_fs_cnt == 1) begin c_fs_e1 = e; c_fs_x = c_x; c_fs_y = c_y; end
                if (c_fs_cnt == 2) c_fs_e2 = e;
            end
            if (!c_vs && e <= 270) c_vs_low++;
            if (p_c_vs && !c_vs && c_vs_fall < 0) begin c_vs_fall = e; c_vs_fall_x = c_x; c_vs_fall_y = c_y; end

            p_a_vo = a_vo; p_a_hs = a_hs; p_a_x = a_x;
            p_b_vo = b_vo; p_b_hs = b_hs; p_b_x = b_x;
            p_c_vs = c_vs;
        end

        chk("a_video_off_clk", a_vo_fall, 2560);
        chk("a_video_off_x", a_vo_fall_x, 640);
        chk("a_hsync_fall_clk", a_hs_fall, 2624);
        chk("a_hsync_fall_x", a_hs_fall_x, 656);
        chk("a_hsync_rise_x", a_hs_rise_x, 752);
        chk("a_hsync_low_clks", a_hs_rise - a_hs_fall, 384);
        chk("a_line_clks", a_wrap, 3200);
        chk("a_wrap_prev_x", a_wrap_px, 799);
        chk("a_wrap_y", a_wrap_y, 1);
        chk("a_vsync_low_cnt", a_vs_low, 0);
        chk("a_frame_start_cnt", a_fs_cnt, 0);

        chk("b_ptick_low_cnt", b_tick0, 0);
        chk("b_video_off_clk", b_vo_fall, 640);
        chk("b_hsync_fall_clk", b_hs_fall, 656);
        chk("b_hsync_fall_x", b_hs_fall_x, 656);
        chk("b_hsync_low_clks", b_hs_rise - b_hs_fall, 96);
        chk("b_line_clks", b_wrap, 800);
        chk("b_wrap_prev_x", b_wrap_px, 799);
        chk("b_wrap_y", b_wrap_y, 1);

        chk("c_frame_start_cnt", c_fs_cnt, 2);
        chk("c_frame_start_clk", c_fs_e1, 269);
        chk("c_frame_period", c_fs_e2 - c_fs_e1, 270);
        chk("c_frame_start_x", c_fs_x, 14);
        chk("c_frame_start_y", c_fs_y, 8);
        chk("c_vsync_low_clks", c_vs_low, 60);
        chk("c_vsync_fall_clk", c_vs_fall, 150);
        chk("c_vsync_fall_x", c_vs_fall_x, 0);
        chk("c_vsync_fall_y", c_vs_fall_y, 5);

        // Mid-frame reset inside both sync pulses, observed without a clk edge.
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(posedge clk); #1;
            if (c_x == 10'd11 && c_y == 10'd6) found = 1'b1;
        end
        chk("c_reach_sync_point", found, 1);
        chk("c_pre_hsync", c_hs, 0);
        chk("c_pre_vsync", c_vs, 0);
        #2;
        rst_c = 1'b1;
        #1;
        chk("c_async_x", c_x, 0);
        chk("c_async_y", c_y, 0);
        chk("c_async_hsync", c_hs, 1);
        chk("c_async_vsync", c_vs, 1);
        chk("c_async_video_on", c_vo, 0);
        chk("c_async_ptick", c_tick, 0);
        chk("c_async_frame_start", c_fs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
